// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage assembling 32-bit words from a byte-wide memory port
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [23:0] lane_buf;
    logic [31:0] hold_inst;

    // Request bytes only while collecting; the address walks the four lanes of the current word
    always_comb begin
        mem_req  = (state == S_FETCH) && !rst;
        mem_addr = pc + {30'd0, byte_cnt};
    end

    // Fetch/hold sequencing; a redirect outranks everything and drops any in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            byte_cnt  <= 2'd0;
            lane_buf  <= 24'd0;
            hold_inst <= NOP_INST;
            if_valid  <= 1'b0;
            if_inst   <= NOP_INST;
            if_pc     <= 32'd0;
        end else if (br && !stall) begin
            pc       <= {br_addr[31:2], 2'b00};
            byte_cnt <= 2'd0;
            state    <= S_FETCH;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        if (byte_cnt != 2'd3) begin
                            lane_buf[8*byte_cnt +: 8] <= mem_rdata;
                            byte_cnt                  <= byte_cnt + 2'd1;
                        end else begin
                            byte_cnt <= 2'd0;
                            if (!stall) begin
                                if_valid <= 1'b1;
                                if_inst  <= {mem_rdata, lane_buf};
                                if_pc    <= pc;
                                pc       <= pc + 32'd4;
                            end else begin
                                hold_inst <= {mem_rdata, lane_buf};
                                state     <= S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid <= 1'b1;
                        if_inst  <= hold_inst;
                        if_pc    <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
